// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the ADC acquisition controller.
// Holds the main and drain FSM state encodings plus the flush lag and byte-split sizes.
// Ports: none (package only).
package adc_acq_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_CAPTURE,
      S_FINISH
   } acq_state_t;

   typedef enum logic [2:0] {
      D_IDLE,
      D_RD,
      D_LAT,
      D_HI,
      D_LO
   } drain_state_t;

   // fifo_empty can trail the true occupancy by this many cycles
   localparam int FLUSH_WAIT    = 2;
   localparam int TX_WORD_BYTES = 2;
   localparam int WORD_WIDTH    = 8 * TX_WORD_BYTES;

endpackage

// File: rtl/acq_drain.sv
// Drain engine: reads one FIFO word at a time and offers it to the UART as two bytes, high byte first.
// Latency: read strobe -> word latched +1 cycle -> high byte offered +2 cycles.
// Backpressure: holds each byte stable until tx_ready; never reads ahead of the UART.
// Ports: enable/clear from the main FSM, written (words stored) in, drained (words sent) out,
//        FIFO empty/data in, rd_req out, UART tx_data/tx_valid out, tx_ready in, idle out.
module acq_drain
   import adc_acq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [CNT_WIDTH-1:0]  written,
   output logic [CNT_WIDTH-1:0]  drained,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  rd_req,
   output logic                  idle,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready
);

   drain_state_t          state, state_n;
   logic [7:0]            lo_byte;
   logic [WORD_WIDTH-1:0] word_ext;

   // narrow ADC words are zero-extended before the byte split
   assign word_ext = WORD_WIDTH'(fifo_data);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= D_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         // the drained < written gate stops a stale fifo_empty=0 from over-reading
         D_IDLE:  if (enable && (drained < written) && !fifo_empty) state_n = D_RD;
         D_RD:    state_n = D_LAT;
         D_LAT:   state_n = D_HI;
         D_HI:    if (tx_ready) state_n = D_LO;
         D_LO:    if (tx_ready) state_n = D_IDLE;
         default: state_n = D_IDLE;
      endcase
   end

   // asserted in the cycle before D_RD so the top can register it into fifo_rd_en
   assign rd_req   = (state == D_IDLE) && (state_n == D_RD);
   assign idle     = (state == D_IDLE);
   assign tx_valid = (state == D_HI) || (state == D_LO);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drained <= '0;
         tx_data <= '0;
         lo_byte <= '0;
      end else begin
         if (clear)                          drained <= '0;
         else if ((state == D_LO) && tx_ready) drained <= drained + CNT_WIDTH'(1);

         if (state == D_LAT) begin
            tx_data <= word_ext[15:8];
            lo_byte <= word_ext[7:0];
         end else if ((state == D_HI) && tx_ready) begin
            tx_data <= lo_byte;
         end
      end
   end

endmodule

// File: rtl/adc_acq_ctrl.sv
// ADC burst controller: flushes stale FIFO words, captures n_samples strobes, streams them to the UART.
// Latency: sample_valid -> fifo_wr_en +1 cycle; done one cycle after the last byte is accepted and drained.
// Backpressure: UART stalls hold the drain; a full FIFO drops the sample and sets sticky overflow.
// Ports: start/n_samples control, sample_valid/adc_data from the ADC, fifo_* to fifo_adc,
//        tx_* to uart_tx, busy/done/overflow status.
module adc_acq_ctrl
   import adc_acq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  n_samples,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] adc_data,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   input  logic                  fifo_full,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   acq_state_t           state, state_n;
   logic [CNT_WIDTH-1:0] n_latched;
   logic [CNT_WIDTH-1:0] captured;
   logic [CNT_WIDTH-1:0] written;
   logic [CNT_WIDTH-1:0] drained;
   logic [2:0]           flush_wait;

   logic start_acc;
   logic take_sample;
   logic flush_rd;
   logic finish_ok;
   logic drain_en;
   logic drain_rd;
   logic drain_idle;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n     = state;
      start_acc   = 1'b0;
      take_sample = 1'b0;
      flush_rd    = 1'b0;
      finish_ok   = 1'b0;
      case (state)
         // busy is still high in the done cycle, so a start there is ignored
         S_IDLE: begin
            if (start && !busy) begin
               start_acc = 1'b1;
               state_n   = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (flush_wait == 3'd0) begin
               if (fifo_empty) state_n  = S_CAPTURE;
               else            flush_rd = 1'b1;
            end
         end
         S_CAPTURE: begin
            if (captured == n_latched) state_n     = S_FINISH;
            else                       take_sample = sample_valid;
         end
         S_FINISH: begin
            if ((drained == written) && drain_idle) begin
               finish_ok = 1'b1;
               state_n   = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign drain_en = (state == S_CAPTURE) || (state == S_FINISH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_latched    <= '0;
         captured     <= '0;
         written      <= '0;
         flush_wait   <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         fifo_rd_en   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;
         fifo_rd_en <= flush_rd | drain_rd;
         done       <= finish_ok;

         if (start_acc) begin
            n_latched  <= n_samples;
            captured   <= '0;
            written    <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
         end else if (state == S_IDLE) begin
            busy <= 1'b0;
         end

         // after a flush read: one cycle for the strobe, then the flag lag, before trusting fifo_empty
         if (start_acc)              flush_wait <= '0;
         else if (flush_rd)          flush_wait <= 3'(FLUSH_WAIT + 1);
         else if (flush_wait != 3'd0) flush_wait <= flush_wait - 3'd1;

         if (take_sample) begin
            captured <= captured + CNT_WIDTH'(1);
            if (!fifo_full) begin
               fifo_wr_en   <= 1'b1;
               fifo_wr_data <= adc_data;
               written      <= written + CNT_WIDTH'(1);
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

   acq_drain #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_drain (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (drain_en),
      .clear      (start_acc),
      .written    (written),
      .drained    (drained),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .rd_req     (drain_rd),
      .idle       (drain_idle),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Bench for adc_acq_ctrl: 16-bit and 12-bit instances, each against a small FIFO model with a lagging empty flag.
// Directed bursts with hand-computed byte streams; monitors sample on the falling edge.
// Ports: none.
module tb_adc_acq_ctrl;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic [15:0] n_samples;
   logic        sample_valid;
   logic [15:0] adc_data;
   logic        fifo_wr_en;
   logic [15:0] fifo_wr_data;
   logic        fifo_full;
   logic        fifo_rd_en;
   logic [15:0] fifo_data = '0;
   logic        fifo_empty = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy, done, overflow;

   logic        start_b;
   logic [15:0] n_samples_b;
   logic        sample_valid_b;
   logic [11:0] adc_data_b;
   logic        fifo_wr_en_b;
   logic [11:0] fifo_wr_data_b;
   logic        fifo_full_b;
   logic        fifo_rd_en_b;
   logic [11:0] fifo_data_b = '0;
   logic        fifo_empty_b = 1'b1;
   logic [7:0]  tx_data_b;
   logic        tx_valid_b;
   logic        tx_ready_b = 1'b1;
   logic        busy_b, done_b, overflow_b;

   adc_acq_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
      .sample_valid(sample_valid), .adc_data(adc_data),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
      .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .overflow(overflow)
   );

   adc_acq_ctrl #(.DATA_WIDTH(12), .CNT_WIDTH(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .n_samples(n_samples_b),
      .sample_valid(sample_valid_b), .adc_data(adc_data_b),
      .fifo_wr_en(fifo_wr_en_b), .fifo_wr_data(fifo_wr_data_b), .fifo_full(fifo_full_b),
      .fifo_rd_en(fifo_rd_en_b), .fifo_data(fifo_data_b), .fifo_empty(fifo_empty_b),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .busy(busy_b), .done(done_b), .overflow(overflow_b)
   );

   // ---------------- FIFO model, 16-bit instance ----------------
   // empty trails occupancy by one cycle; full counts a write already in flight
   logic [15:0] fa_mem [DEPTH];
   int fa_cnt = 0, fa_c = 0, fa_wp = 0, fa_rp = 0, fa_drop = 0, fa_under = 0;
   assign fifo_full = (fa_cnt + int'(fifo_wr_en)) >= DEPTH;

   always @(posedge clk) begin
      fa_c = fa_cnt;
      fifo_empty <= (fa_cnt == 0);
      if (fifo_rd_en) begin
         if (fa_c == 0) fa_under++;
         else begin
            fifo_data <= fa_mem[fa_rp];
            fa_rp = (fa_rp + 1) % DEPTH;
            fa_c--;
         end
      end
      if (fifo_wr_en) begin
         if (fa_c >= DEPTH) fa_drop++;
         else begin
            fa_mem[fa_wp] = fifo_wr_data;
            fa_wp = (fa_wp + 1) % DEPTH;
            fa_c++;
         end
      end
      fa_cnt <= fa_c;
   end

   // ---------------- FIFO model, 12-bit instance ----------------
   logic [11:0] fb_mem [DEPTH];
   int fb_cnt = 0, fb_c = 0, fb_wp = 0, fb_rp = 0;
   assign fifo_full_b = (fb_cnt + int'(fifo_wr_en_b)) >= DEPTH;

   always @(posedge clk) begin
      fb_c = fb_cnt;
      fifo_empty_b <= (fb_cnt == 0);
      if (fifo_rd_en_b && fb_c > 0) begin
         fifo_data_b <= fb_mem[fb_rp];
         fb_rp = (fb_rp + 1) % DEPTH;
         fb_c--;
      end
      if (fifo_wr_en_b && fb_c < DEPTH) begin
         fb_mem[fb_wp] = fifo_wr_data_b;
         fb_wp = (fb_wp + 1) % DEPTH;
         fb_c++;
      end
      fb_cnt <= fb_c;
   end

   // ---------------- UART ready driver ----------------
   // mode 0: never ready, 1: always ready, 2: ready only after 10 stalled cycles per byte
   int rdy_mode = 1;
   int stall_cnt = 0;
   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: tx_ready = 1'b0;
            1: tx_ready = 1'b1;
            default: begin
               if (tx_ready) begin
                  tx_ready  = 1'b0;
                  stall_cnt = 0;
               end else if (tx_valid) begin
                  stall_cnt++;
                  if (stall_cnt >= 10) tx_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------- monitors (cumulative; tests use base snapshots) ----------------
   logic [7:0]  bq [$];
   logic [15:0] wq [$];
   logic [7:0]  bq_b [$];
   int done_cnt = 0, rd_cnt = 0, stab_err = 0, txv_cnt = 0, bytes_at_done = 0, done_b_cnt = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] stall_dat = '0;

   always @(negedge clk) begin
      if (tx_valid && tx_ready) bq.push_back(tx_data);
      if (tx_valid) txv_cnt++;
      if (tx_valid && !tx_ready) begin
         if (stall_prev && tx_data != stall_dat) stab_err++;
         stall_prev = 1'b1;
         stall_dat  = tx_data;
      end else begin
         stall_prev = 1'b0;
      end
      if (fifo_rd_en) rd_cnt++;
      if (fifo_wr_en) wq.push_back(fifo_wr_data);
      if (done) begin
         done_cnt++;
         bytes_at_done = bq.size();
      end
      if (tx_valid_b && tx_ready_b) bq_b.push_back(tx_data_b);
      if (done_b) done_b_cnt++;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   int bq_base = 0, wq_base = 0, done_base = 0, rd_base = 0, stab_base = 0, txv_base = 0;
   logic [7:0] ebq [$];

   task automatic snap();
      bq_base   = bq.size();
      wq_base   = wq.size();
      done_base = done_cnt;
      rd_base   = rd_cnt;
      stab_base = stab_err;
      txv_base  = txv_cnt;
      ebq.delete();
   endtask

   task automatic check_stream(input string tag);
      logic [31:0] got;
      chk({tag, "_nbytes"}, 32'(bq.size() - bq_base), 32'(ebq.size()));
      for (int i = 0; i < ebq.size(); i++) begin
         got = (bq_base + i < bq.size()) ? 32'(bq[bq_base + i]) : 32'h100;
         chk($sformatf("%s_byte%0d", tag, i), got, 32'(ebq[i]));
      end
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start(input logic [15:0] n);
      start     = 1'b1;
      n_samples = n;
      cycle();
      start     = 1'b0;
   endtask

   task automatic strobe(input logic [15:0] d);
      sample_valid = 1'b1;
      adc_data     = d;
      cycle();
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string tag);
      for (int i = 0; i < max && busy; i++) cycle();
      chk({tag, "_idle"}, 32'(busy), 32'h0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; n_samples = '0; sample_valid = 1'b0; adc_data = '0;
      start_b = 1'b0; n_samples_b = '0; sample_valid_b = 1'b0; adc_data_b = '0;
      repeat (3) cycle();

      // reset values
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_ovf",   32'(overflow), 32'h0);
      chk("rst_txv",   32'(tx_valid), 32'h0);
      chk("rst_txd",   32'(tx_data), 32'h0);
      chk("rst_wr",    32'({fifo_wr_en, fifo_wr_data}), 32'h0);
      chk("rst_rd",    32'(fifo_rd_en), 32'h0);
      rst_n = 1'b1;
      cycle();

      // basic burst
      snap();
      rdy_mode = 1;
      pulse_start(16'd4);
      chk("t1_busy_rise", 32'(busy), 32'h1);
      repeat (4) cycle();
      strobe(16'h1234);
      chk("t1_wr_lat", 32'({fifo_wr_en, fifo_wr_data}), 32'h11234);
      cycle();
      strobe(16'hABCD);
      strobe(16'h0001);
      strobe(16'hFFFF);
      wait_idle(300, "t1");
      ebq = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF};
      check_stream("t1");
      chk("t1_done_once", 32'(done_cnt - done_base), 32'h1);
      chk("t1_ovf", 32'(overflow), 32'h0);

      // UART back-pressure
      snap();
      rdy_mode = 2;
      pulse_start(16'd3);
      repeat (3) cycle();
      strobe(16'h0102);
      strobe(16'h0304);
      strobe(16'h0506);
      wait_idle(800, "t2");
      ebq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      check_stream("t2");
      chk("t2_stable", 32'(stab_err - stab_base), 32'h0);
      chk("t2_done_after6", 32'(bytes_at_done - bq_base), 32'd6);
      chk("t2_done_once", 32'(done_cnt - done_base), 32'h1);

      // overflow: UART stalled while 20 samples arrive back to back
      snap();
      rdy_mode = 0;
      pulse_start(16'd20);
      repeat (3) cycle();
      for (int i = 0; i < 20; i++) strobe(16'h1000 + 16'(i));
      rdy_mode = 1;
      wait_idle(600, "t3");
      chk("t3_ovf", 32'(overflow), 32'h1);
      chk("t3_written_lt20", 32'((wq.size() - wq_base) < 20), 32'h1);
      for (int i = 0; i < wq.size() - wq_base; i++) begin
         ebq.push_back(8'h10);
         ebq.push_back(8'(i));
      end
      check_stream("t3");
      chk("t3_model_drop", 32'(fa_drop), 32'h0);

      // stale flush: abort a stalled burst by reset, leaving 5 words in the FIFO
      rdy_mode = 0;
      pulse_start(16'd10);
      repeat (3) cycle();
      for (int i = 0; i < 6; i++) strobe(16'h5A00 + 16'(i));
      repeat (6) cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();
      chk("t4_preload", 32'(fa_cnt), 32'd5);
      snap();
      rdy_mode = 1;
      pulse_start(16'd2);
      repeat (40) cycle();
      chk("t4_flush_rd", 32'(rd_cnt - rd_base), 32'd5);
      strobe(16'hC0DE);
      strobe(16'hBEEF);
      wait_idle(300, "t4");
      ebq = '{8'hC0, 8'hDE, 8'hBE, 8'hEF};
      check_stream("t4");
      chk("t4_underread", 32'(fa_under), 32'h0);

      // zero length
      snap();
      pulse_start(16'd0);
      wait_idle(100, "t5z");
      chk("t5z_done", 32'(done_cnt - done_base), 32'h1);
      chk("t5z_no_txv", 32'(txv_cnt - txv_base), 32'h0);

      // start while busy and start in the done cycle are both ignored
      snap();
      pulse_start(16'd2);
      cycle();
      pulse_start(16'd5);
      chk("t5_busy_hold", 32'(busy), 32'h1);
      repeat (2) cycle();
      strobe(16'h1111);
      strobe(16'h2222);
      strobe(16'h3333);
      for (int i = 0; i < 300 && !done; i++) cycle();
      chk("t5_done_seen", 32'(done), 32'h1);
      start = 1'b1;
      n_samples = 16'd7;
      cycle();
      start = 1'b0;
      cycle();
      chk("t5_done_start_ign", 32'(busy), 32'h0);
      ebq = '{8'h11, 8'h11, 8'h22, 8'h22};
      check_stream("t5");
      chk("t5_done_once", 32'(done_cnt - done_base), 32'h1);

      // 12-bit build
      start_b = 1'b1;
      n_samples_b = 16'd1;
      cycle();
      start_b = 1'b0;
      repeat (3) cycle();
      sample_valid_b = 1'b1;
      adc_data_b = 12'hABC;
      cycle();
      sample_valid_b = 1'b0;
      for (int i = 0; i < 100 && busy_b; i++) cycle();
      chk("t6_idle", 32'(busy_b), 32'h0);
      chk("t6_nbytes", 32'(bq_b.size()), 32'd2);
      chk("t6_byte0", (bq_b.size() > 0) ? 32'(bq_b[0]) : 32'h100, 32'h0A);
      chk("t6_byte1", (bq_b.size() > 1) ? 32'(bq_b[1]) : 32'h100, 32'hBC);
      chk("t6_done", 32'(done_b_cnt), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_acq_ctrl.md
# adc_acq_ctrl

Acquisition controller that sequences one ADC capture burst through `fifo_adc` and streams the buffered samples to the byte-wide UART transmitter. On `start` it flushes stale FIFO contents, captures exactly `n_samples` ADC strobes into the FIFO, and drains every stored word concurrently as two bytes, high byte first. It sits between the ADC front end, `fifo_adc` and `uart_tx`, and reports busy, done and overflow to the top-level control logic.

## Interface
- `DATA_WIDTH`, 16: ADC/FIFO word width. Legal range 9..16; words narrower than 16 bits are zero-extended to 16 before byte split.
- `CNT_WIDTH`, 16: width of the sample counters and `n_samples`.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a burst. Ignored while `busy`.
- `n_samples` in CNT_WIDTH: burst length, latched on an accepted `start`.
- `sample_valid` in 1: ADC strobe; `adc_data` is valid this cycle.
- `adc_data` in DATA_WIDTH: ADC sample.
- `fifo_wr_en` out 1: FIFO write strobe (registered).
- `fifo_wr_data` out DATA_WIDTH: FIFO write data (registered).
- `fifo_full` in 1: FIFO full flag.
- `fifo_rd_en` out 1: FIFO read strobe (registered, one-cycle pulses).
- `fifo_data` in DATA_WIDTH: FIFO read data; valid 1 cycle after `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag. It lags FIFO occupancy by up to 2 cycles.
- `tx_data` out 8: byte to the UART.
- `tx_valid` out 1: byte offer.
- `tx_ready` in 1: UART accepts the byte when `tx_valid && tx_ready`.
- `busy` out 1: high from accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when the burst completes.
- `overflow` out 1: sticky flag for a dropped sample. Cleared by reset or by an accepted `start`.

## Operation
- **Main FSM:** IDLE → FLUSH → CAPTURE → FINISH → IDLE.
- **IDLE:** on `start`, latch `n_samples`, clear counters and `overflow`, assert `busy`, go to FLUSH.
- **FLUSH:**
  - If `fifo_empty`, go to CAPTURE.
  - Otherwise pulse `fifo_rd_en` and discard the data.
  - Wait 2 cycles before sampling `fifo_empty` again, to cover the flag lag.
  - Flushed words are not counted and not transmitted.
- **CAPTURE:**
  - Each `sample_valid` with `captured < n_latched` is accepted.
  - If `fifo_full` is low, register `fifo_wr_en=1` and `fifo_wr_data=adc_data` for the next cycle, and increment `written`.
  - If `fifo_full` is high, drop the sample and set `overflow`.
  - Increment `captured` in both cases.
  - When `captured == n_latched`, further strobes are ignored and the FSM goes to FINISH.
- **FINISH:** wait until `drained == written` and the drain FSM is in D_IDLE. Then pulse `done`, drop `busy`, return to IDLE.
- **`n_samples == 0`:** FLUSH still runs, CAPTURE exits immediately, and `done` follows.
- **Drain FSM:** D_IDLE → D_RD → D_LAT → D_HI → D_LO → D_IDLE.
  - Active only in CAPTURE or FINISH.
  - D_IDLE: when `drained < written` and `!fifo_empty`, go to D_RD.
  - D_RD: pulse `fifo_rd_en`, go to D_LAT.
  - D_LAT: latch `fifo_data`, zero-extended to 16 bits, go to D_HI.
  - D_HI: present `word[15:8]` with `tx_valid` high until `tx_ready`, go to D_LO.
  - D_LO: present `word[7:0]` with `tx_valid` high until `tx_ready`, increment `drained`, go to D_IDLE.
  - The D_IDLE gate on `drained < written` stops a stale `fifo_empty=0` from causing an over-read.
- **Counters:** `captured`, `written` and `drained` are CNT_WIDTH wide and never wrap, since all are bounded by `n_latched`.
- **Reset:** may occur in any state. All FSMs return to IDLE/D_IDLE and every output is forced to its reset value. FIFO contents are left in place and are removed by the next FLUSH.

## Timing
- **Reset values:** `fifo_wr_en=0`, `fifo_wr_data=0`, `fifo_rd_en=0`, `tx_data=0`, `tx_valid=0`, `busy=0`, `done=0`, `overflow=0`.
- **`busy`:** rises the cycle after `start` is sampled.
- **Write latency:** `sample_valid` at cycle t gives `fifo_wr_en` at t+1.
- **Read latency:** `fifo_rd_en` at t gives data latched at t+1 and `tx_valid` (high byte) from t+2.
- **Handshake:** `tx_data` is stable while `tx_valid && !tx_ready`. `tx_valid` is deasserted for at least 1 cycle between words and stays high between the two bytes of a word.
- **`done`:** asserted the cycle after the FINISH condition holds. A `start` arriving in the `done` cycle is ignored.
- **Simultaneous events:** a write and a read may occur in the same cycle.

## Structure
- Shared package `adc_acq_pkg`:
  - main FSM state enum;
  - drain FSM state enum;
  - `FLUSH_WAIT=2`;
  - `TX_WORD_BYTES=2`.
- One sub-module, `acq_drain`, implementing the drain FSM and byte split.
- The top level holds the main FSM, capture path and counters.

## Test plan
- **Basic burst:** `n_samples=4`, samples 0x1234, 0xABCD, 0x0001, 0xFFFF, `tx_ready` tied high.
  - Expect bytes 12 34 AB CD 00 01 FF FF, in order.
  - Expect `done` exactly once and `overflow=0`.
- **UART back-pressure:** `n_samples=3`, `tx_ready` low for 10 cycles per byte.
  - `tx_data` holds steady while stalled.
  - No bytes are lost or duplicated.
  - `done` occurs only after the 6th byte.
- **Overflow:** FIFO_DEPTH=8, `tx_ready=0` until 20 samples have been strobed, `n_samples=20`.
  - `overflow=1`.
  - Bytes sent equal 2×`written` (<40), and the sent data matches the first accepted samples.
- **Stale flush:** preload the FIFO with 5 words via reset mid-capture, then `start` with `n_samples=2`.
  - 5 `fifo_rd_en` pulses before CAPTURE.
  - Only the 2 new samples are transmitted.
- **Zero length / ignored start:** `n_samples=0`.
  - `done` pulses and no `tx_valid` is ever asserted.
  - A second `start` while `busy` in a normal burst is ignored, and `n_latched` is unchanged.
- **12-bit build:** DATA_WIDTH=12, sample 0xABC.
  - Expect bytes 0A BC.
